// File: rtl/seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider (and its sibling
// shift-add multiplier): FSM state encoding, default width, counter sizing.
package seq_divider_pkg;

    // Operand width used by both the divider and the multiplier by default.
    localparam int DEFAULT_WIDTH = 8;

    // Step counter width for the default operand width.
    localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // Two-bit FSM encoding kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Counter width needed to hold 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem,q} left, trial-subtract the
// divisor, and keep the difference (quotient bit 1) or restore (bit 0).
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Shift-subtract-restore; the compare is done on WIDTH+1 bits so the
    // bit shifted out of the remainder is never lost.
    always_comb begin
        rem_sh = {rem, q[WIDTH-1]};
        q_sh   = {q[WIDTH-2:0], 1'b0};
        fits   = (rem_sh >= {1'b0, dvs});
        diff   = rem_sh[WIDTH-1:0] - dvs;
        if (fits) begin
            rem_next = diff;
            q_next   = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rem_next = rem_sh[WIDTH-1:0];
            q_next   = q_sh;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with the
// same start/busy/done handshake as the shift-add multiplier.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             last_step;
    logic             zero_dvs;

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_step = (state == ST_RUN) && (count == CW'(WIDTH - 1));
    assign zero_dvs  = (divisor == '0);

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_acc),
        .q        (q_acc),
        .dvs      (dvs),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    // Control: state sequencing, step counter, busy level and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_RUN: begin
                    count <= count + CW'(1);
                    if (last_step) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (accept) begin
                        if (zero_dvs) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            count <= '0;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Datapath: operand capture, per-step accumulator update, result transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_acc     <= '0;
            q_acc       <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (zero_dvs) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                rem_acc <= '0;
                q_acc   <= dividend;
                dvs     <= divisor;
            end
        end else if (state == ST_RUN) begin
            rem_acc <= rem_next;
            q_acc   <= q_next;
            if (last_step) begin
                quotient    <= q_next;
                remainder   <= rem_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider (WIDTH = 8).
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks;
    int errors;

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for done; reports cycles to done
    // counted from the accepting edge, and how many sampled cycles had busy=1.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output int ticks, output int busy_cnt);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ticks    = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && ticks < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            ticks++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout %0d/%0d: done never seen after %0d cycles", a, b, ticks);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_q got %0d want 0", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_r got %0d want 0", remainder); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int t, bc;
        run_div(8'd100, 8'd7, t, bc);
        checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL basic_q got %0d want 14", quotient); end
        checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL basic_r got %0d want 2", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
        checks++; if (t !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", t); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
        checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL basic_hold_q got %0d want 14", quotient); end
    endtask

    task automatic test_boundaries;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] vq [4];
        logic [7:0] vr [4];
        int t, bc;
        va = '{8'd255, 8'd5, 8'd0, 8'd255};
        vb = '{8'd1,   8'd9, 8'd3, 8'd255};
        vq = '{8'd255, 8'd0, 8'd0, 8'd1};
        vr = '{8'd0,   8'd5, 8'd0, 8'd0};
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], t, bc);
            checks++;
            if (quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL bound_%0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                         va[i], vb[i], quotient, remainder, div_by_zero, vq[i], vr[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_by_zero;
        int t, bc;
        run_div(8'd42, 8'd0, t, bc);
        checks++; if (quotient !== 8'd255) begin errors++; $display("FAIL dbz_q got %0d want 255", quotient); end
        checks++; if (remainder !== 8'd42) begin errors++; $display("FAIL dbz_r got %0d want 42", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
        checks++; if (t !== 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", t); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dbz_busy got %b want 0", busy); end
        tick();
        tick();
        tick();
        checks++;
        if (quotient !== 8'd255 || remainder !== 8'd42 || div_by_zero !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL dbz_hold got q=%0d r=%0d dbz=%b done=%b want q=255 r=42 dbz=1 done=0",
                     quotient, remainder, div_by_zero, done);
        end
    endtask

    task automatic test_busy_ignore;
        int t;
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        tick();
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 8'd77;
        divisor  = 8'd3;
        t = 5;
        while (done !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        checks++; if (t !== 9) begin errors++; $display("FAIL ignore_latency got %0d want 9", t); end
        checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2) begin
            errors++;
            $display("FAIL ignore_result got q=%0d r=%0d want q=14 r=2", quotient, remainder);
        end
    endtask

    // Entered while the previous operation is in its DONE cycle.
    task automatic test_back_to_back;
        int t, bc;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_precond done got %b want 1", done); end
        run_div(8'd50, 8'd5, t, bc);
        checks++;
        if (quotient !== 8'd10 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL b2b_result got q=%0d r=%0d want q=10 r=0", quotient, remainder);
        end
        checks++; if (t !== 9) begin errors++; $display("FAIL b2b_latency got %0d want 9", t); end
        tick();
    endtask

    task automatic test_reset_mid;
        int t, bc;
        int seen;
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen); end
        run_div(8'd9, 8'd2, t, bc);
        checks++;
        if (quotient !== 8'd4 || remainder !== 8'd1 || t !== 9) begin
            errors++;
            $display("FAIL midrst_after got q=%0d r=%0d lat=%0d want q=4 r=1 lat=9", quotient, remainder, t);
        end
        tick();
    endtask

    task automatic test_random;
        int t, bc;
        int a, b, eq, er;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(1, 255);
            eq = a / b;
            er = a % b;
            run_div(a[7:0], b[7:0], t, bc);
            checks++;
            if (int'(quotient) != eq || int'(remainder) != er || div_by_zero !== 1'b0 ||
                int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
                errors++;
                $display("FAIL rand_%0d %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                         n, a, b, quotient, remainder, div_by_zero, eq, er);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_by_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
